control_unit_pipelined: RTL and testbench

- Registered successor to the RV32IM combinational decoder. Decodes one instruction per cycle into the ID/EX control bundle.
- Registers the bundle into the ID/EX stage and supports flush (bubble insertion).
- Sequences multi-cycle M-extension ops with a latency counter that stalls fetch/decode.
- Sits between the IF/ID register and the EX stage.

---
 rtl/control_unit_pipelined.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_control_unit_pipelined.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_pipelined.sv
// control_unit_pipelined
//
// Registered RV32IM control unit. Decodes one instruction per cycle from the
// IF/ID register and latches the resulting control bundle into the ID/EX
// stage one cycle later. Multi-cycle M-extension ops hold decode with STALL
// for (latency - 1) cycles, during which bubbles are latched.
//
// Precedence at each clock edge, highest first: RESET, FLUSH, busy
// countdown, normal decode.
//
// Optional build macro:
//   ILLEGAL_TRAP_EN - adds output illegal_instr. It pulses for one cycle,
//                     aligned with the bundle, when a valid instruction is
//                     not in RV32IM. Without the macro such instructions
//                     become silent bubbles.
//
// Parameters:
//   MUL_LATENCY  EX cycles taken by MUL/MULH/MULHSU/MULHU (>= 1)
//   DIV_LATENCY  EX cycles taken by DIV/DIVU/REM/REMU (>= 1)
//   CNT_W        busy-counter width, 2^CNT_W > max(latency) - 1
//
// Ports:
//   CLK               rising-edge clock
//   RESET             synchronous active-low reset
//   INSTRUCTION       instruction word from IF/ID
//   INSTR_VALID       INSTRUCTION is valid this cycle
//   FLUSH             squash the instruction currently being decoded
//   STALL             upstream must hold INSTRUCTION/INSTR_VALID
//   VALID_OUT         registered bundle is a real instruction
//   alu_signal        ALU op
//   reg_file_write    register write enable
//   main_mem_write    {store, funct3[1:0]}
//   main_mem_read     {load, funct3}
//   branch_control    branch/jump type
//   immediate_select  immediate format
//   operand_1_select  1 = PC, 0 = rs1
//   operand_2_select  1 = immediate, 0 = rs2
//   reg_write_select  00 ALU, 01 memory, 10 PC+4
//   muldiv_busy       M-op in flight (same as STALL)
//   illegal_instr     (ILLEGAL_TRAP_EN only) unsupported instruction pulse

module control_unit_pipelined #(
  parameter int unsigned MUL_LATENCY = 2,
  parameter int unsigned DIV_LATENCY = 33,
  parameter int unsigned CNT_W       = 6
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        INSTR_VALID,
  input  logic        FLUSH,
  output logic        STALL,
  output logic        VALID_OUT,
  output logic [4:0]  alu_signal,
  output logic        reg_file_write,
  output logic [2:0]  main_mem_write,
  output logic [3:0]  main_mem_read,
  output logic [3:0]  branch_control,
  output logic [3:0]  immediate_select,
  output logic        operand_1_select,
  output logic        operand_2_select,
  output logic [1:0]  reg_write_select,
  output logic        muldiv_busy
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegal_instr
`endif
);

  // RV32IM major opcodes
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  // Immediate format codes
  localparam logic [3:0] ImmR     = 4'd0;
  localparam logic [3:0] ImmI     = 4'd1;
  localparam logic [3:0] ImmS     = 4'd2;
  localparam logic [3:0] ImmB     = 4'd3;
  localparam logic [3:0] ImmU     = 4'd4;
  localparam logic [3:0] ImmJ     = 4'd5;
  localparam logic [3:0] ImmShift = 4'd6;

  // Counter load values: the op stalls for (latency - 1) cycles
  localparam logic [CNT_W-1:0] MulCnt   = CNT_W'(MUL_LATENCY - 1);
  localparam logic [CNT_W-1:0] DivCnt   = CNT_W'(DIV_LATENCY - 1);
  localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
  localparam bit               MulMulti = (MUL_LATENCY > 1);
  localparam bit               DivMulti = (DIV_LATENCY > 1);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] alu_signal;
    logic       reg_file_write;
    logic [2:0] main_mem_write;
    logic [3:0] main_mem_read;
    logic [3:0] branch_control;
    logic [3:0] immediate_select;
    logic       operand_1_select;
    logic       operand_2_select;
    logic [1:0] reg_write_select;
  } ctrl_t;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  ctrl_t            dec;
  logic             legal;
  logic             is_m;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = INSTRUCTION[6:0];
  assign funct3 = INSTRUCTION[14:12];
  assign funct7 = INSTRUCTION[31:25];

  // Register/immediate fields are consumed by the datapath, not here
  logic unused_fields;
  assign unused_fields = ^{INSTRUCTION[24:15], INSTRUCTION[11:7]};

  // Combinational decode; illegal encodings decode to an all-zero bubble
  always_comb begin
    dec   = '0;
    legal = 1'b0;
    is_m  = 1'b0;
    case (opcode)
      OpReg: begin
        if (funct7 == F7Base || funct7 == F7Alt || funct7 == F7Mul) begin
          legal              = 1'b1;
          is_m               = (funct7 == F7Mul);
          dec.alu_signal     = {INSTRUCTION[25], INSTRUCTION[30], funct3};
          dec.reg_file_write = 1'b1;
          dec.immediate_select = ImmR;
        end
      end
      OpImm: begin
        legal = 1'b1;
        // Only the right shifts carry a sub-op bit in instr[30]
        dec.alu_signal       = {1'b0, (funct3 == 3'b101) ? INSTRUCTION[30] : 1'b0, funct3};
        dec.immediate_select = (funct3 == 3'b001 || funct3 == 3'b101) ? ImmShift : ImmI;
        dec.operand_2_select = 1'b1;
        dec.reg_file_write   = 1'b1;
      end
      OpLui: begin
        legal                = 1'b1;
        dec.alu_signal       = 5'b11000;
        dec.immediate_select = ImmU;
        dec.operand_2_select = 1'b1;
        dec.reg_file_write   = 1'b1;
      end
      OpAuipc: begin
        legal                = 1'b1;
        dec.immediate_select = ImmU;
        dec.operand_1_select = 1'b1;
        dec.operand_2_select = 1'b1;
        dec.reg_file_write   = 1'b1;
      end
      OpJal: begin
        legal                = 1'b1;
        dec.immediate_select = ImmJ;
        dec.branch_control   = 4'b0001;
        dec.operand_1_select = 1'b1;
        dec.operand_2_select = 1'b1;
        dec.reg_file_write   = 1'b1;
        dec.reg_write_select = 2'b10;
      end
      OpJalr: begin
        legal                = 1'b1;
        dec.immediate_select = ImmI;
        dec.branch_control   = 4'b0010;
        dec.operand_2_select = 1'b1;
        dec.reg_file_write   = 1'b1;
        dec.reg_write_select = 2'b10;
      end
      OpBranch: begin
        legal                = 1'b1;
        dec.immediate_select = ImmB;
        dec.branch_control   = {1'b1, funct3};
        dec.operand_2_select = 1'b1;
      end
      OpLoad: begin
        legal                = 1'b1;
        dec.immediate_select = ImmI;
        dec.main_mem_read    = {1'b1, funct3};
        dec.operand_2_select = 1'b1;
        dec.reg_file_write   = 1'b1;
        dec.reg_write_select = 2'b01;
      end
      OpStore: begin
        legal                = 1'b1;
        dec.immediate_select = ImmS;
        dec.main_mem_write   = {1'b1, funct3[1:0]};
        dec.operand_2_select = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    dec.valid = legal;
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  // Next-state: bubble unless an instruction is accepted in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = '0;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = 1'b0;
`endif
    if (FLUSH) begin
      // Squash decode and cancel any in-flight stall
      state_d = StIdle;
      cnt_d   = '0;
    end else if (state_q == StBusy) begin
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        state_d = StIdle;
      end
    end else if (INSTR_VALID) begin
      ctrl_d = dec;
`ifdef ILLEGAL_TRAP_EN
      illegal_d = ~legal;
`endif
      if (legal && is_m) begin
        if (funct3[2] ? DivMulti : MulMulti) begin
          state_d = StBusy;
          cnt_d   = funct3[2] ? DivCnt : MulCnt;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ctrl_q  <= '0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = illegal_q;
`endif

  assign STALL            = (state_q == StBusy);
  assign muldiv_busy      = (state_q == StBusy);
  assign VALID_OUT        = ctrl_q.valid;
  assign alu_signal       = ctrl_q.alu_signal;
  assign reg_file_write   = ctrl_q.reg_file_write;
  assign main_mem_write   = ctrl_q.main_mem_write;
  assign main_mem_read    = ctrl_q.main_mem_read;
  assign branch_control   = ctrl_q.branch_control;
  assign immediate_select = ctrl_q.immediate_select;
  assign operand_1_select = ctrl_q.operand_1_select;
  assign operand_2_select = ctrl_q.operand_2_select;
  assign reg_write_select = ctrl_q.reg_write_select;

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Bench for control_unit_pipelined. Two instances share stimulus: u0 with
// default latencies (MUL 2, DIV 33) and u1 with MUL 1, DIV 3.
module tb_control_unit_pipelined;

  typedef struct packed {
    logic       valid;
    logic [4:0] alu;
    logic       rfw;
    logic [2:0] mw;
    logic [3:0] mr;
    logic [3:0] br;
    logic [3:0] imm;
    logic       op1;
    logic       op2;
    logic [1:0] wsel;
  } bundle_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    bundle_t     exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        ivalid = 1'b0;
  logic        flush = 1'b0;

  logic       stall [2];
  logic       vo    [2];
  logic [4:0] alu   [2];
  logic       rfw   [2];
  logic [2:0] mw    [2];
  logic [3:0] mr    [2];
  logic [3:0] br    [2];
  logic [3:0] imm   [2];
  logic       op1   [2];
  logic       op2   [2];
  logic [1:0] wsel  [2];
  logic       busy  [2];
  logic       ill   [2];
  bundle_t    got   [2];

  int errors = 0;
  int checks = 0;

  // Reference model state: expected bundle and remaining stall cycles
  bundle_t exp_b    [2];
  int      rem      [2];
  bit      exp_ill  [2];
  int      lat_mul  [2] = '{2, 1};
  int      lat_div  [2] = '{33, 3};

  always #5 clk = ~clk;

  control_unit_pipelined u0 (
    .CLK(clk), .RESET(reset_n), .INSTRUCTION(instr), .INSTR_VALID(ivalid), .FLUSH(flush),
    .STALL(stall[0]), .VALID_OUT(vo[0]), .alu_signal(alu[0]), .reg_file_write(rfw[0]),
    .main_mem_write(mw[0]), .main_mem_read(mr[0]), .branch_control(br[0]),
    .immediate_select(imm[0]), .operand_1_select(op1[0]), .operand_2_select(op2[0]),
    .reg_write_select(wsel[0]), .muldiv_busy(busy[0])
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(ill[0])
`endif
  );

  control_unit_pipelined #(.MUL_LATENCY(1), .DIV_LATENCY(3), .CNT_W(2)) u1 (
    .CLK(clk), .RESET(reset_n), .INSTRUCTION(instr), .INSTR_VALID(ivalid), .FLUSH(flush),
    .STALL(stall[1]), .VALID_OUT(vo[1]), .alu_signal(alu[1]), .reg_file_write(rfw[1]),
    .main_mem_write(mw[1]), .main_mem_read(mr[1]), .branch_control(br[1]),
    .immediate_select(imm[1]), .operand_1_select(op1[1]), .operand_2_select(op2[1]),
    .reg_write_select(wsel[1]), .muldiv_busy(busy[1])
`ifdef ILLEGAL_TRAP_EN
    , .illegal_instr(ill[1])
`endif
  );

`ifndef ILLEGAL_TRAP_EN
  assign ill[0] = 1'b0;
  assign ill[1] = 1'b0;
`endif

  assign got[0] = {vo[0], alu[0], rfw[0], mw[0], mr[0], br[0], imm[0], op1[0], op2[0], wsel[0]};
  assign got[1] = {vo[1], alu[1], rfw[1], mw[1], mr[1], br[1], imm[1], op1[1], op2[1], wsel[1]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Decode straight from the ISA tables; unsupported encodings give a bubble
  function automatic bundle_t ref_decode(input logic [31:0] ins, output bit legal,
                                         output bit is_m);
    bundle_t    b = '0;
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    legal = 1'b1;
    is_m  = 1'b0;
    case (ins[6:0])
      7'b0110011: begin
        if (f7 == 7'h00 || f7 == 7'h20 || f7 == 7'h01) begin
          b.alu = {ins[25], ins[30], f3};
          b.rfw = 1'b1;
          is_m  = (f7 == 7'h01);
        end else legal = 1'b0;
      end
      7'b0010011: begin
        b.alu = {1'b0, (f3 == 3'b101) ? ins[30] : 1'b0, f3};
        b.imm = (f3 == 3'b001 || f3 == 3'b101) ? 4'd6 : 4'd1;
        b.rfw = 1'b1;
      end
      7'b0110111: begin b.alu = 5'b11000; b.imm = 4'd4; b.rfw = 1'b1; end
      7'b0010111: begin b.imm = 4'd4; b.op1 = 1'b1; b.rfw = 1'b1; end
      7'b1101111: begin
        b.imm = 4'd5; b.br = 4'b0001; b.op1 = 1'b1; b.rfw = 1'b1; b.wsel = 2'b10;
      end
      7'b1100111: begin b.imm = 4'd1; b.br = 4'b0010; b.rfw = 1'b1; b.wsel = 2'b10; end
      7'b1100011: begin b.imm = 4'd3; b.br = {1'b1, f3}; end
      7'b0000011: begin b.imm = 4'd1; b.mr = {1'b1, f3}; b.rfw = 1'b1; b.wsel = 2'b01; end
      7'b0100011: begin b.imm = 4'd2; b.mw = {1'b1, f3[1:0]}; end
      default: legal = 1'b0;
    endcase
    if (!legal) return '0;
    b.op2   = (b.imm != 4'd0);
    b.valid = 1'b1;
    return b;
  endfunction

  task automatic model_step(input int k);
    bundle_t d;
    bit      lg, m;
    exp_ill[k] = 1'b0;
    if (!reset_n || flush) begin
      exp_b[k] = '0;
      rem[k]   = 0;
    end else if (rem[k] > 0) begin
      exp_b[k] = '0;
      rem[k]   = rem[k] - 1;
    end else if (!ivalid) begin
      exp_b[k] = '0;
    end else begin
      d          = ref_decode(instr, lg, m);
      exp_b[k]   = d;
      exp_ill[k] = !lg;
      if (m) rem[k] = (instr[14] ? lat_div[k] : lat_mul[k]) - 1;
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s.u%0d.bundle", name, k), 32'(got[k]), 32'(exp_b[k]));
      chk($sformatf("%s.u%0d.stall", name, k), 32'(stall[k]), 32'(rem[k] > 0));
      chk($sformatf("%s.u%0d.busy", name, k), 32'(busy[k]), 32'(rem[k] > 0));
`ifdef ILLEGAL_TRAP_EN
      chk($sformatf("%s.u%0d.illegal", name, k), 32'(ill[k]), 32'(exp_ill[k]));
`endif
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; ivalid = 1'b0; flush = 1'b0;
    tick("rst");
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    logic [6:0]  ops [12] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                              7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011,
                              7'b0001011, 7'b1110011};
    r[6:0] = ops[$urandom_range(0, 11)];
    if (r[6:0] == 7'b0110011) begin
      case ($urandom_range(0, 4))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        2, 3: r[31:25] = 7'h01;
        default: ;
      endcase
    end
    return r;
  endfunction

  localparam logic [31:0] AddI = 32'h003100B3;
  localparam logic [31:0] DivI = 32'h023140B3;
  localparam logic [31:0] MulI = 32'h023100B3;
  localparam bundle_t     AddB = '{1'b1, 5'b00000, 1'b1, 3'b000, 4'b0000, 4'b0000, 4'd0,
                                   1'b0, 1'b0, 2'b00};

  vec_t vecs [11];
  int   n;

  initial begin
    //               valid alu       rfw  mw      mr       br       imm  op1   op2   wsel
    vecs[0]  = '{"add",   AddI,         AddB};
    vecs[1]  = '{"sub",   32'h403100B3, '{1, 5'b01000, 1, 3'b000, 4'b0000, 4'b0000, 0, 0, 0, 2'b00}};
    vecs[2]  = '{"srai",  32'h40315093, '{1, 5'b01101, 1, 3'b000, 4'b0000, 4'b0000, 6, 0, 1, 2'b00}};
    vecs[3]  = '{"lw",    32'h00012083, '{1, 5'b00000, 1, 3'b000, 4'b1010, 4'b0000, 1, 0, 1, 2'b01}};
    vecs[4]  = '{"sw",    32'h00312023, '{1, 5'b00000, 0, 3'b110, 4'b0000, 4'b0000, 2, 0, 1, 2'b00}};
    vecs[5]  = '{"beq",   32'h00208063, '{1, 5'b00000, 0, 3'b000, 4'b0000, 4'b1000, 3, 0, 1, 2'b00}};
    vecs[6]  = '{"jal",   32'h000000EF, '{1, 5'b00000, 1, 3'b000, 4'b0000, 4'b0001, 5, 1, 1, 2'b10}};
    vecs[7]  = '{"lui",   32'h123450B7, '{1, 5'b11000, 1, 3'b000, 4'b0000, 4'b0000, 4, 0, 1, 2'b00}};
    vecs[8]  = '{"auipc", 32'h00000097, '{1, 5'b00000, 1, 3'b000, 4'b0000, 4'b0000, 4, 1, 1, 2'b00}};
    vecs[9]  = '{"jalr",  32'h000100E7, '{1, 5'b00000, 1, 3'b000, 4'b0000, 4'b0010, 1, 0, 1, 2'b10}};
    vecs[10] = '{"cust0", 32'h0000000B, '0};

    // Reset held two cycles with a valid add in front of it
    reset_n = 1'b0; ivalid = 1'b1; instr = AddI;
    tick("rst0");
    tick("rst1");
    chk("reset.bundle", 32'(got[0]), 32'h0);
    chk("reset.stall", 32'(stall[0]), 32'h0);
    reset_n = 1'b1;
    tick("rel");
    chk("release.add", 32'(got[0]), 32'(AddB));

    // Decode sweep
    for (int i = 0; i < 11; i++) begin
      instr = vecs[i].instr; ivalid = 1'b1;
      tick(vecs[i].name);
      chk({"dec.", vecs[i].name}, 32'(got[0]), 32'(vecs[i].exp));
    end

    // Illegal opcode: bubble, plus trap pulse when the feature is built in
    instr = 32'h0000000B; ivalid = 1'b1;
    tick("ill");
    chk("ill.valid", 32'(vo[0]), 32'h0);
`ifdef ILLEGAL_TRAP_EN
    chk("ill.pulse", 32'(ill[0]), 32'h1);
`endif
    ivalid = 1'b0;
    tick("ill2");
`ifdef ILLEGAL_TRAP_EN
    chk("ill.pulse_end", 32'(ill[0]), 32'h0);
`endif

    // DIV then add: 32 stall cycles of bubbles, add on the first IDLE edge
    do_reset();
    instr = DivI; ivalid = 1'b1;
    tick("div");
    chk("div.valid", 32'(vo[0]), 32'h1);
    chk("div.alu", 32'(alu[0]), 32'h14);
    instr = AddI;
    n = 0;
    while (stall[0] && n < 100) begin
      tick("divwait");
      n++;
      chk("div.bubble", 32'(vo[0]), 32'h0);
    end
    chk("div.stall_cycles", n, 32);
    tick("divadd");
    chk("div.add_after", 32'(got[0]), 32'(AddB));

    // MUL latency 1 back-to-back on u1: no stall, two valid bundles
    do_reset();
    instr = MulI; ivalid = 1'b1;
    tick("mul1");
    chk("mul1.valid", 32'(vo[1]), 32'h1);
    chk("mul1.stall", 32'(stall[1]), 32'h0);
    tick("mul2");
    chk("mul2.valid", 32'(vo[1]), 32'h1);
    chk("mul2.alu", 32'(alu[1]), 32'h10);
    chk("mul2.stall", 32'(stall[1]), 32'h0);

    // FLUSH on the 5th stall cycle of a DIV
    do_reset();
    instr = DivI; ivalid = 1'b1;
    tick("fdiv");
    instr = AddI;
    for (int i = 0; i < 4; i++) tick("fwait");
    chk("flush.pre_stall", 32'(stall[0]), 32'h1);
    flush = 1'b1;
    tick("flush");
    chk("flush.bubble", 32'(vo[0]), 32'h0);
    chk("flush.stall", 32'(stall[0]), 32'h0);
    flush = 1'b0;
    tick("fadd");
    chk("flush.add", 32'(got[0]), 32'(AddB));

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      instr   = rand_instr();
      ivalid  = ($urandom_range(0, 9) < 8);
      flush   = ($urandom_range(0, 49) == 0);
      reset_n = ($urandom_range(0, 199) != 0);
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
